// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer: turns board controls into a one-clk cpu_ce pulse
// for the model CPU, and reports run state and the number of pulses issued.
module cpu_run_ctrl #(
  parameter int DIV       = 25000000,
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             BRK_EN,
  input  logic [7:0]       BRK_ADDR,
  input  logic [7:0]       PC,
  input  logic             HALT,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic             brk_hit,
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam int PS_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_BREAK   = 2'd2,
    ST_HALTED  = 2'd3
  } run_state_t;

  run_state_t        state_r;
  run_state_t        state_nxt_s;
  logic              run_meta_r;
  logic              run_sync_r;
  logic              step_meta_r;
  logic              step_sync_r;
  logic              step_db_r;
  logic              step_db_d_r;
  logic [DB_W-1:0]   db_cnt_r;
  logic [PS_W-1:0]   presc_r;
  logic [PS_W-1:0]   presc_nxt_s;
  logic              cpu_ce_r;
  logic              brk_hit_r;
  logic [CNT_W-1:0]  cyc_cnt_r;
  logic [7:0]        pc_last_r;
  logic              pc_last_v_r;
  logic              ce_nxt_s;
  logic              step_pulse_s;
  logic              tick_s;
  logic              bp_match_s;

  // Synchronize RUN/STEP and debounce the synchronized STEP level.
  always_ff @(posedge clk) begin
    if (RESET) begin
      run_meta_r  <= 1'b0;
      run_sync_r  <= 1'b0;
      step_meta_r <= 1'b0;
      step_sync_r <= 1'b0;
      step_db_r   <= 1'b0;
      step_db_d_r <= 1'b0;
      db_cnt_r    <= {DB_W{1'b0}};
    end else begin
      run_meta_r  <= RUN;
      run_sync_r  <= run_meta_r;
      step_meta_r <= STEP;
      step_sync_r <= step_meta_r;
      step_db_d_r <= step_db_r;
      if (step_sync_r == step_db_r) begin
        db_cnt_r <= {DB_W{1'b0}};
      end else if (db_cnt_r == DB_LAST) begin
        step_db_r <= step_sync_r;
        db_cnt_r  <= {DB_W{1'b0}};
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end
  end

  assign step_pulse_s = step_db_r & ~step_db_d_r;
  assign tick_s       = (presc_r == PS_LAST);
  // Fire only on arrival at the address, not on every microcycle spent there.
  assign bp_match_s   = BRK_EN && (PC == BRK_ADDR) && (!pc_last_v_r || (pc_last_r != BRK_ADDR));

  // Next-state and pulse decision; HALT outranks everything but RESET.
  always_comb begin
    state_nxt_s = state_r;
    ce_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (HALT) begin
          state_nxt_s = ST_HALTED;
        end else if (run_sync_r) begin
          state_nxt_s = ST_RUNNING;
        end else if (step_pulse_s) begin
          ce_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUNNING: begin
        if (HALT) begin
          state_nxt_s = ST_HALTED;
        end else if (!run_sync_r) begin
          state_nxt_s = ST_IDLE;
        end else if (tick_s) begin
          if (bp_match_s) begin
            state_nxt_s = ST_BREAK;
          end else begin
            ce_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_RUNNING;
        end
      end
      ST_BREAK: begin
        if (HALT) begin
          state_nxt_s = ST_HALTED;
        end else if (step_pulse_s) begin
          ce_nxt_s    = 1'b1;
          state_nxt_s = run_sync_r ? ST_RUNNING : ST_IDLE;
        end else if (!run_sync_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Prescaler advances only while staying in RUNNING, so every entry starts at 0.
  always_comb begin
    presc_nxt_s = {PS_W{1'b0}};
    if ((state_r == ST_RUNNING) && (state_nxt_s == ST_RUNNING)) begin
      presc_nxt_s = tick_s ? {PS_W{1'b0}} : (presc_r + PS_W'(1));
    end else begin
      presc_nxt_s = {PS_W{1'b0}};
    end
  end

  // State register, prescaler and registered status outputs.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      presc_r   <= {PS_W{1'b0}};
      cpu_ce_r  <= 1'b0;
      brk_hit_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      presc_r   <= presc_nxt_s;
      cpu_ce_r  <= ce_nxt_s;
      brk_hit_r <= (state_nxt_s == ST_BREAK);
    end
  end

  // Pulse bookkeeping: cycle count and the PC seen when each pulse was decided.
  always_ff @(posedge clk) begin
    if (RESET) begin
      cyc_cnt_r   <= {CNT_W{1'b0}};
      pc_last_r   <= 8'h00;
      pc_last_v_r <= 1'b0;
    end else if (ce_nxt_s) begin
      cyc_cnt_r   <= cyc_cnt_r + CNT_W'(1);
      pc_last_r   <= PC;
      pc_last_v_r <= 1'b1;
    end else begin
      cyc_cnt_r   <= cyc_cnt_r;
      pc_last_r   <= pc_last_r;
      pc_last_v_r <= pc_last_v_r;
    end
  end

  assign cpu_ce  = cpu_ce_r;
  assign state   = state_r;
  assign brk_hit = brk_hit_r;
  assign cyc_cnt = cyc_cnt_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DIV=4, DB_CYCLES=3, CNT_W=4.
module tb_cpu_run_ctrl;

  logic       clk = 1'b0;
  logic       RESET;
  logic       RUN;
  logic       STEP;
  logic       BRK_EN;
  logic [7:0] BRK_ADDR;
  logic [7:0] PC;
  logic       HALT;
  logic       cpu_ce;
  logic [1:0] state;
  logic       brk_hit;
  logic [3:0] cyc_cnt;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_cnt;
  logic       pc_model_en;
  int         pc_idx;
  logic [7:0] pc_tab [0:5];

  cpu_run_ctrl #(.DIV(4), .DB_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .RESET(RESET), .RUN(RUN), .STEP(STEP), .BRK_EN(BRK_EN),
    .BRK_ADDR(BRK_ADDR), .PC(PC), .HALT(HALT), .cpu_ce(cpu_ce),
    .state(state), .brk_hit(brk_hit), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // One clock, then compare every output against the expected values for that cycle.
  task automatic clk_step(input logic exp_ce, input logic [1:0] exp_state, input string tag);
    @(posedge clk);
    #1;
    if (exp_ce) begin
      exp_cnt = exp_cnt + 4'd1;
      if (pc_model_en) begin
        if (pc_idx < 5) pc_idx = pc_idx + 1;
        PC = pc_tab[pc_idx];
      end
    end
    check({tag, ".cpu_ce"},  32'(cpu_ce),  32'(exp_ce));
    check({tag, ".state"},   32'(state),   32'(exp_state));
    check({tag, ".brk_hit"}, 32'(brk_hit), 32'(exp_state == 2'd2));
    check({tag, ".cyc_cnt"}, 32'(cyc_cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic e;
    int   k;
    pc_tab[0] = 8'h03; pc_tab[1] = 8'h04; pc_tab[2] = 8'h05;
    pc_tab[3] = 8'h05; pc_tab[4] = 8'h05; pc_tab[5] = 8'h06;
    pc_model_en = 1'b0;
    pc_idx      = 0;
    RESET = 1'b1; RUN = 1'b0; STEP = 1'b0; BRK_EN = 1'b0;
    BRK_ADDR = 8'h00; PC = 8'h00; HALT = 1'b0;
    exp_cnt = 4'd0;

    // Reset state
    for (int i = 0; i < 3; i++) clk_step(1'b0, 2'd0, "reset");
    RESET = 1'b0;

    // Run mode: sync takes 2 clk, RUNNING on 3rd, first pulse after DIV more
    RUN = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      e = (i >= 7) && (((i - 7) % 4) == 0);
      clk_step(e, (i >= 3) ? 2'd1 : 2'd0, "run");
    end
    check("run.pulses", 32'(cyc_cnt), 32'd9);
    // RUN drops; the tick landing on the exit cycle must not pulse
    RUN = 1'b0;
    clk_step(1'b0, 2'd1, "run_drop");
    clk_step(1'b0, 2'd1, "run_drop");
    for (int i = 0; i < 3; i++) clk_step(1'b0, 2'd0, "run_drop");

    // Bouncy STEP in IDLE: 1-0-1 then held 10 clk, one pulse only
    for (int j = 1; j <= 20; j++) begin
      STEP = (j == 1) || (j >= 3 && j <= 12);
      clk_step(j == 8, 2'd0, "step_idle");
    end
    check("step_idle.cnt", 32'(cyc_cnt), 32'd10);

    // Breakpoint at 5, PC advancing 3,4,5,5,5,6 per pulse
    pc_model_en = 1'b1;
    pc_idx      = 0;
    PC          = pc_tab[0];
    BRK_ADDR    = 8'h05;
    BRK_EN      = 1'b1;
    RUN         = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      clk_step((i == 7) || (i == 11), (i == 15) ? 2'd2 : ((i >= 3) ? 2'd1 : 2'd0), "brk_entry");
    end
    BRK_EN = 1'b0;
    for (int i = 0; i < 6; i++) clk_step(1'b0, 2'd2, "brk_hold");
    BRK_EN = 1'b1;
    STEP   = 1'b1;
    for (int j = 1; j <= 21; j++) begin
      e = (j == 6) || (j == 10) || (j == 14) || (j == 18);
      clk_step(e, (j < 6) ? 2'd2 : 2'd1, "brk_step");
      if (j == 8) STEP = 1'b0;
    end
    check("brk.pc_after", 32'(PC), 32'h06);

    // HALT arriving on the tick cycle wins, then RUN/STEP are ignored
    HALT = 1'b1;
    clk_step(1'b0, 2'd3, "halt_tick");
    RUN  = 1'b0;
    STEP = 1'b1;
    for (int i = 0; i < 10; i++) clk_step(1'b0, 2'd3, "halted");
    RUN  = 1'b1;
    STEP = 1'b0;
    for (int i = 0; i < 10; i++) clk_step(1'b0, 2'd3, "halted");
    HALT = 1'b0; RUN = 1'b0; RESET = 1'b1;
    exp_cnt = 4'd0;
    clk_step(1'b0, 2'd0, "halt_reset");
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) clk_step(1'b0, 2'd0, "post_reset");

    // 4-bit counter wrap over 17 pulses
    pc_model_en = 1'b0;
    BRK_EN      = 1'b0;
    RUN         = 1'b1;
    k           = 0;
    for (int i = 1; i <= 71; i++) begin
      e = (i >= 7) && (((i - 7) % 4) == 0);
      clk_step(e, (i >= 3) ? 2'd1 : 2'd0, "wrap");
      if (e) begin
        k = k + 1;
        if (k == 15) check("wrap.p15", 32'(cyc_cnt), 32'd15);
        if (k == 16) check("wrap.p16", 32'(cyc_cnt), 32'd0);
        if (k == 17) check("wrap.p17", 32'(cyc_cnt), 32'd1);
      end
    end
    check("wrap.pulses", 32'(k), 32'd17);

    // RESET for one clk with prescaler at DIV-2
    clk_step(1'b0, 2'd1, "pre_rst");
    clk_step(1'b0, 2'd1, "pre_rst");
    RESET   = 1'b1;
    exp_cnt = 4'd0;
    clk_step(1'b0, 2'd0, "mid_rst");
    RESET = 1'b0;
    for (int i = 1; i <= 5; i++) clk_step(1'b0, (i >= 3) ? 2'd1 : 2'd0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
